// File: rtl/buffer_arbiter.sv
// buffer_arbiter: single-port frame-buffer read arbiter between disparity engine and display scanout
module buffer_arbiter #(
  parameter int WIDTH = 20,
  parameter int HEIGHT = 7,
  parameter int CW = 10,
  parameter int MEM_AW = 12,
  parameter int RD_LAT = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              eng_req,
  input  logic              image_sel,
  input  logic [CW-1:0]     buffer_href,
  input  logic [CW-1:0]     buffer_vref,
  output logic              eng_ack,
  output logic [7:0]        image_data,
  output logic              eng_valid,
  output logic              buffer_ready,
  input  logic              disp_req,
  input  logic [CW-1:0]     disp_href,
  input  logic [CW-1:0]     disp_vref,
  output logic              disp_ack,
  output logic [7:0]        disp_data,
  output logic              disp_valid,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_data
);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);
  typedef enum logic [1:0] {IDLE, SERVE, FORCE_ENG} state_t;
  state_t state;
  logic [SW-1:0] starve_cnt;
  logic [3:0] out_cnt;
  logic reset_q, force_eng, eng_oob, disp_oob, sel_oob, any_ack;
  logic [MEM_AW-1:0] eng_addr, disp_addr;
  logic [RD_LAT:0] tag_v, tag_d, tag_o;
  always_comb begin
    force_eng = state == FORCE_ENG || starve_cnt == LIM;
    eng_ack = ~reset & eng_req & (force_eng | ~disp_req);
    disp_ack = ~reset & disp_req & ~eng_ack;
    any_ack = eng_ack | disp_ack;
    eng_addr = MEM_AW'((image_sel ? 32'(WIDTH * HEIGHT) : 32'd0) + 32'(buffer_vref) * 32'(WIDTH) + 32'(buffer_href));
    disp_addr = MEM_AW'(32'(2 * WIDTH * HEIGHT) + 32'(disp_vref) * 32'(WIDTH) + 32'(disp_href));
    eng_oob = 32'(buffer_href) >= 32'(WIDTH) || 32'(buffer_vref) >= 32'(HEIGHT);
    disp_oob = 32'(disp_href) >= 32'(WIDTH) || 32'(disp_vref) >= 32'(HEIGHT);
    sel_oob = disp_ack ? disp_oob : eng_oob;
    buffer_ready = ~reset_q & (out_cnt == 4'd0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      starve_cnt <= '0;
      out_cnt <= '0;
      reset_q <= 1'b1;
      mem_en <= 1'b0;
      mem_addr <= '0;
      tag_v <= '0;
      tag_d <= '0;
      tag_o <= '0;
      eng_valid <= 1'b0;
      disp_valid <= 1'b0;
      image_data <= '0;
      disp_data <= '0;
    end else begin
      reset_q <= 1'b0;
      state <= !(eng_req || disp_req) ? IDLE :
               state == FORCE_ENG ? (eng_ack ? SERVE : FORCE_ENG) :
               (starve_cnt == LIM && !eng_ack) ? FORCE_ENG : SERVE;
      starve_cnt <= eng_ack ? '0 : (eng_req && starve_cnt != LIM) ? starve_cnt + 1'b1 : starve_cnt;
      out_cnt <= out_cnt + {3'b0, eng_ack} - {3'b0, eng_valid};
      mem_en <= any_ack & ~sel_oob;
      if (any_ack) mem_addr <= disp_ack ? disp_addr : eng_addr;
      tag_v <= {tag_v[RD_LAT-1:0], any_ack};
      tag_d <= {tag_d[RD_LAT-1:0], disp_ack};
      tag_o <= {tag_o[RD_LAT-1:0], sel_oob};
      eng_valid <= tag_v[RD_LAT] & ~tag_d[RD_LAT];
      disp_valid <= tag_v[RD_LAT] & tag_d[RD_LAT];
      if (tag_v[RD_LAT] && !tag_d[RD_LAT]) image_data <= tag_o[RD_LAT] ? 8'h00 : mem_data;
      if (tag_v[RD_LAT] && tag_d[RD_LAT]) disp_data <= tag_o[RD_LAT] ? 8'h00 : mem_data;
    end
  end
endmodule

// File: tb/tb_buffer_arbiter.sv
// tb_buffer_arbiter: directed self-checking bench for buffer_arbiter
module tb_buffer_arbiter;
  logic clk = 1'b0, reset = 1'b1, eng_req = 1'b0, image_sel = 1'b0, disp_req = 1'b0;
  logic [9:0] buffer_href = '0, buffer_vref = '0, disp_href = '0, disp_vref = '0;
  logic eng_ack, eng_valid, buffer_ready, disp_ack, disp_valid, mem_en;
  logic [7:0] image_data, disp_data, mem_data = '0;
  logic [11:0] mem_addr;
  logic [7:0] mem [0:4095];
  int checks = 0, errors = 0;
  buffer_arbiter dut (
    .clk(clk), .reset(reset), .eng_req(eng_req), .image_sel(image_sel),
    .buffer_href(buffer_href), .buffer_vref(buffer_vref), .eng_ack(eng_ack),
    .image_data(image_data), .eng_valid(eng_valid), .buffer_ready(buffer_ready),
    .disp_req(disp_req), .disp_href(disp_href), .disp_vref(disp_vref),
    .disp_ack(disp_ack), .disp_data(disp_data), .disp_valid(disp_valid),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  function automatic logic [1:0] pat(input int k);
    return (k % 5 == 4) ? 2'b10 : 2'b01;
  endfunction
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
    mem[183] = 8'hA5;
    mem[305] = 8'h3C;
    eng_req = 1'b1;
    disp_req = 1'b1;
    tick;
    tick;
    mid;
    check("rst_ack", 32'({eng_ack, disp_ack}), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_valid", 32'({eng_valid, disp_valid}), 32'd0);
    check("rst_data", 32'({image_data, disp_data}), 32'd0);
    check("rst_ready", 32'(buffer_ready), 32'd0);
    tick;
    reset = 1'b0;
    eng_req = 1'b0;
    disp_req = 1'b0;
    mid;
    check("ready_lag", 32'(buffer_ready), 32'd0);
    tick;
    mid;
    check("ready_up", 32'(buffer_ready), 32'd1);
    tick;
    eng_req = 1'b1;
    image_sel = 1'b1;
    buffer_href = 10'd3;
    buffer_vref = 10'd2;
    mid;
    check("t1_ack", 32'({eng_ack, disp_ack}), 32'd2);
    tick;
    eng_req = 1'b0;
    mid;
    check("t1_mem_en", 32'(mem_en), 32'd1);
    check("t1_addr", 32'(mem_addr), 32'd183);
    check("t1_ready_n1", 32'(buffer_ready), 32'd0);
    tick;
    mid;
    check("t1_valid_n2", 32'(eng_valid), 32'd0);
    check("t1_ready_n2", 32'(buffer_ready), 32'd0);
    tick;
    mid;
    check("t1_valid_n3", 32'({eng_valid, disp_valid}), 32'd2);
    check("t1_data", 32'(image_data), 32'hA5);
    check("t1_ready_n3", 32'(buffer_ready), 32'd0);
    tick;
    mid;
    check("t1_valid_n4", 32'(eng_valid), 32'd0);
    check("t1_ready_n4", 32'(buffer_ready), 32'd1);
    check("t1_hold", 32'(image_data), 32'hA5);
    tick;
    disp_req = 1'b1;
    disp_href = 10'd5;
    disp_vref = 10'd1;
    mid;
    check("t2_ack", 32'({eng_ack, disp_ack}), 32'd1);
    tick;
    disp_req = 1'b0;
    mid;
    check("t2_addr", 32'({mem_en, mem_addr}), 32'h1000 | 32'd305);
    tick;
    mid;
    check("t2_valid_n2", 32'({eng_valid, disp_valid}), 32'd0);
    tick;
    mid;
    check("t2_valid_n3", 32'({eng_valid, disp_valid}), 32'd1);
    check("t2_data", 32'(disp_data), 32'h3C);
    tick;
    disp_href = 10'd0;
    disp_vref = 10'd0;
    image_sel = 1'b0;
    buffer_href = 10'd1;
    buffer_vref = 10'd0;
    for (int i = 0; i < 13; i++) begin
      eng_req = i < 10;
      disp_req = i < 10;
      mid;
      check($sformatf("t3_ack%0d", i), 32'({eng_ack, disp_ack}), i < 10 ? 32'(pat(i)) : 32'd0);
      check($sformatf("t3_val%0d", i), 32'({eng_valid, disp_valid}), i >= 3 ? 32'(pat(i - 3)) : 32'd0);
      if (i >= 3 && pat(i - 3) == 2'b10) check($sformatf("t3_edat%0d", i), 32'(image_data), 32'(mem[1]));
      if (i >= 3 && pat(i - 3) == 2'b01) check($sformatf("t3_ddat%0d", i), 32'(disp_data), 32'(mem[280]));
      tick;
    end
    eng_req = 1'b1;
    buffer_href = 10'd20;
    buffer_vref = 10'd0;
    mid;
    check("t4_ack", 32'(eng_ack), 32'd1);
    tick;
    eng_req = 1'b0;
    mid;
    check("t4_mem_en", 32'(mem_en), 32'd0);
    tick;
    mid;
    check("t4_valid_n2", 32'(eng_valid), 32'd0);
    tick;
    mid;
    check("t4_valid_n3", 32'(eng_valid), 32'd1);
    check("t4_data", 32'(image_data), 32'd0);
    tick;
    for (int i = 0; i < 8; i++) begin
      eng_req = i < 4;
      buffer_href = 10'(i);
      mid;
      if (i < 4) check($sformatf("t5_ack%0d", i), 32'(eng_ack), 32'd1);
      check($sformatf("t5_val%0d", i), 32'(eng_valid), (i >= 3 && i < 7) ? 32'd1 : 32'd0);
      if (i >= 3 && i < 7) check($sformatf("t5_dat%0d", i), 32'(image_data), 32'(mem[i - 3]));
      tick;
    end
    eng_req = 1'b1;
    buffer_href = 10'd5;
    mid;
    check("t6_ack0", 32'(eng_ack), 32'd1);
    tick;
    buffer_href = 10'd6;
    mid;
    check("t6_ack1", 32'(eng_ack), 32'd1);
    tick;
    eng_req = 1'b0;
    reset = 1'b1;
    mid;
    tick;
    reset = 1'b0;
    mid;
    check("t6_valid_a", 32'({eng_valid, disp_valid}), 32'd0);
    check("t6_mem", 32'({mem_en, mem_addr}), 32'd0);
    check("t6_data", 32'({image_data, disp_data}), 32'd0);
    check("t6_ready_a", 32'(buffer_ready), 32'd0);
    tick;
    mid;
    check("t6_valid_b", 32'({eng_valid, disp_valid}), 32'd0);
    check("t6_ready_b", 32'(buffer_ready), 32'd1);
    tick;
    mid;
    check("t6_valid_c", 32'({eng_valid, disp_valid}), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/buffer_arbiter.md
# buffer_arbiter

Single-port frame-buffer read arbiter shared between the disparity engine and the VGA display scanout. The memory holds three planes of `WIDTH*HEIGHT` bytes: left image, right image and disparity map. The block maps (select, href, vref) coordinates to memory addresses and grants one read per cycle. Display has priority; an anti-starvation counter protects the engine. Read data is returned to its owner in issue order.

## Interface
- `WIDTH`, 20, pixels per row
- `HEIGHT`, 7, rows per plane
- `CW`, 10, width of href/vref coordinates
- `MEM_AW`, 12, memory address width; must satisfy 3*WIDTH*HEIGHT <= 2^MEM_AW
- `RD_LAT`, 1, memory read latency in cycles (1..4)
- `STARVE_LIM`, 4, consecutive cycles the engine can be denied before it is forced through

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `eng_req`  in  1  engine read request; held with address until `eng_ack`
- `image_sel`  in  1  engine plane select: 0 = left, 1 = right
- `buffer_href`  in  CW  engine column
- `buffer_vref`  in  CW  engine row
- `eng_ack`  out  1  combinational; request accepted at this edge
- `image_data`  out  8  engine read data
- `eng_valid`  out  1  `image_data` valid (one-cycle pulse per read)
- `buffer_ready`  out  1  high when out of reset and no engine read is in flight
- `disp_req`  in  1  display read request (disparity plane)
- `disp_href`  in  CW  display column
- `disp_vref`  in  CW  display row
- `disp_ack`  out  1  combinational accept
- `disp_data`  out  8  display read data
- `disp_valid`  out  1  `disp_data` valid pulse
- `mem_en`  out  1  registered memory read enable
- `mem_addr`  out  MEM_AW  registered read address
- `mem_data`  in  8  memory data, valid RD_LAT cycles after the `mem_en` cycle

## Operation
- Address = plane*WIDTH*HEIGHT + vref*WIDTH + href.
  - Engine plane is `image_sel`.
  - Display plane is always 2.
  - Computed at full width, then truncated to MEM_AW.
- Out-of-range request (href >= WIDTH or vref >= HEIGHT):
  - Accepted and acked normally.
  - `mem_en` stays low for that slot.
  - Owner receives 8'h00 at normal latency, which preserves ordering.
- FSM states:
  - IDLE: no request last cycle.
  - SERVE: normal arbitration.
  - FORCE_ENG: engine has priority.
- Transitions:
  - Any request moves the FSM to SERVE.
  - In SERVE, `starve_cnt == STARVE_LIM` moves it to FORCE_ENG.
  - FORCE_ENG returns to SERVE after the engine ack.
  - No requests for one cycle returns the FSM to IDLE.
- Grant rules:
  - IDLE/SERVE: display wins when both request.
  - FORCE_ENG: engine wins.
  - At most one ack per cycle; never both.
- `starve_cnt`:
  - Increments each cycle `eng_req & ~eng_ack`.
  - Saturates at STARVE_LIM.
  - Clears on `eng_ack`.
- Owner tag pipeline: depth RD_LAT+1, entries {valid, owner, oob}. It routes `mem_data` (or 8'h00 for out-of-range slots) to the owner's data register, and pulses that owner's valid.
- Engine outstanding counter: +1 on `eng_ack`, -1 on `eng_valid`. `buffer_ready = ~reset_q & (count == 0)`.

## Timing
- Latency: ack in cycle N → `mem_en`/`mem_addr` in N+1 → `mem_data` in N+1+RD_LAT → `*_valid`/`*_data` registered in N+2+RD_LAT (N+3 at default).
- Throughput: one grant per cycle total; back-to-back grants to the same requester are allowed.
- Requester may change its address and `req` in the cycle after its ack.
- `image_data` and `disp_data` hold their last value between valid pulses.
- Reset values:
  - `mem_en`, `mem_addr`, `eng_valid`, `disp_valid`, `image_data`, `disp_data`, `buffer_ready`, `starve_cnt` = 0.
  - FSM = IDLE.
- `eng_ack`/`disp_ack` are forced 0 while `reset` is high.
- `buffer_ready` rises the cycle after reset deasserts.
- Reset mid-operation: all in-flight tags are dropped; no valid pulse appears for any read issued before reset.
- Requests to both owners in the same cycle follow the grant rules; the loser keeps `req` high and is not acked.

## Test plan
- Single engine read, `image_sel`=1, href=3, vref=2 → `eng_ack` cycle N; `mem_addr`=183 with `mem_en` in N+1; memory returns 8'hA5 → `image_data`=8'hA5 with `eng_valid` in N+3; `buffer_ready` low N+1..N+3, high at N+4.
- Display read href=5, vref=1 → `mem_addr`=305; `disp_valid` pulse after 3 cycles with returned data; `eng_valid` stays 0.
- Both requests held continuously → display acked 4 cycles, then engine acked in cycle 5 (FORCE_ENG); pattern repeats; valid pulses match the ack order exactly.
- Engine href=20, vref=0 (out of range) → acked; `mem_en` stays 0 in the slot; `image_data`=8'h00 with `eng_valid` 3 cycles later.
- Back-to-back engine reads at addresses 0..3 in consecutive cycles → four consecutive `eng_valid` pulses carrying memory[0..3] in order.
- Issue 2 engine reads, assert `reset` 1 cycle later for 1 cycle → no `eng_valid` pulses; all outputs 0; `buffer_ready` high the cycle after reset.
